tdc_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single RS232_TX serial transmitter among N_REQ TDC measurement channels.
- Each channel raises a level request with an 8-bit count.
- The arbiter captures one request and sends a header byte identifying the channel, then the count byte.
- It sequences STT/EOT on the transmitter exactly as the single-channel TDC top does: one-cycle STT, guard cycles, then wait for EOT.
- It sits between the per-channel capture FSMs and RS232_TX.

---
 rtl/tdc_tx_arbiter_if.sv | 37 +++
 rtl/tdc_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_tdc_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_tx_arbiter_if.sv
// Bundle between the TDC channel capture FSMs, the shared RS232_TX and the arbiter.
// The arbiter uses the master view; channels and the transmitter sit on the slave view.
interface tdc_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         tx_d;
    logic               tx_stt;
    logic               tx_eot;
    logic               busy;
    logic [IDX_W-1:0]   grant_id;

    modport master (
        input  req,
        input  req_data,
        input  tx_eot,
        output ack,
        output tx_d,
        output tx_stt,
        output busy,
        output grant_id
    );

    modport slave (
        output req,
        output req_data,
        output tx_eot,
        input  ack,
        input  tx_d,
        input  tx_stt,
        input  busy,
        input  grant_id
    );
endinterface

// File: rtl/tdc_tx_arbiter.sv
// Round-robin arbiter sharing one RS232_TX among N_REQ TDC channels.
// Each grant sends an optional channel header byte followed by the captured count byte.
module tdc_tx_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         IDX_W     = 2,
    parameter logic [7:0] HDR_BASE  = 8'hA0,
    parameter bit         HDR_EN    = 1'b1,
    parameter int         GUARD_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    tdc_tx_arbiter_if.master bus
);

    localparam int              GC_W       = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GC_W-1:0] GUARD_LOAD = GC_W'(GUARD_CYC - 1);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("tdc_tx_arbiter: N_REQ must be in 2..8");
        end
        if (IDX_W != $clog2(N_REQ)) begin : g_bad_idx_w
            $error("tdc_tx_arbiter: IDX_W must equal ceil(log2(N_REQ))");
        end
        if ((HDR_BASE & 8'((1 << IDX_W) - 1)) != 8'h00) begin : g_bad_hdr_base
            $error("tdc_tx_arbiter: low IDX_W bits of HDR_BASE must be zero");
        end
        if (GUARD_CYC < 1) begin : g_bad_guard
            $error("tdc_tx_arbiter: GUARD_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        HDR_STT,
        HDR_GUARD,
        HDR_WAIT,
        DAT_STT,
        DAT_GUARD,
        DAT_WAIT
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_q;
    logic [7:0]       data_q;
    logic [N_REQ-1:0] ack_q;
    logic [7:0]       tx_d_q;
    logic             tx_stt_q;
    logic             busy_q;
    logic [GC_W-1:0]  guard_q;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [7:0]       win_data;
    logic             capture;

    // Channel index base+offs, wrapping modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
        return HDR_BASE | {{(8 - IDX_W){1'b0}}, idx};
    endfunction

    // First requester at or after the pointer, circularly.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.req[rr_idx(ptr_q, k)]) begin
                win_idx   = rr_idx(ptr_q, k);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_data = bus.req_data[8*k +: 8];
            end
        end
    end

    // Requests are only looked at while the transmitter reports idle.
    assign capture = (state_q == IDLE) && win_found && bus.tx_eot;

    always_ff @(posedge clk) begin
        if (capture) begin
            data_q <= win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            tx_d_q   <= 8'h00;
            tx_stt_q <= 1'b0;
            busy_q   <= 1'b0;
            guard_q  <= '0;
        end else begin
            ack_q    <= '0;
            tx_stt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        grant_q  <= win_idx;
                        busy_q   <= 1'b1;
                        ack_q    <= onehot(win_idx);
                        tx_stt_q <= 1'b1;
                        if (HDR_EN) begin
                            tx_d_q  <= hdr_byte(win_idx);
                            state_q <= HDR_STT;
                        end else begin
                            tx_d_q  <= win_data;
                            state_q <= DAT_STT;
                        end
                    end
                end
                HDR_STT: begin
                    guard_q <= GUARD_LOAD;
                    state_q <= HDR_GUARD;
                end
                // EOT may still show the previous idle level right after STT.
                HDR_GUARD: begin
                    if (guard_q == '0) begin
                        state_q <= HDR_WAIT;
                    end else begin
                        guard_q <= guard_q - GC_W'(1);
                    end
                end
                HDR_WAIT: begin
                    if (bus.tx_eot) begin
                        tx_d_q   <= data_q;
                        tx_stt_q <= 1'b1;
                        state_q  <= DAT_STT;
                    end
                end
                DAT_STT: begin
                    guard_q <= GUARD_LOAD;
                    state_q <= DAT_GUARD;
                end
                DAT_GUARD: begin
                    if (guard_q == '0) begin
                        state_q <= DAT_WAIT;
                    end else begin
                        guard_q <= guard_q - GC_W'(1);
                    end
                end
                DAT_WAIT: begin
                    if (bus.tx_eot) begin
                        busy_q  <= 1'b0;
                        ptr_q   <= rr_idx(grant_q, 1);
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_d     = tx_d_q;
    assign bus.tx_stt   = tx_stt_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_tdc_tx_arbiter.sv
// Bench for tdc_tx_arbiter: header+data instance (A) and data-only, long-guard instance (B),
// each driven against a simple RS232_TX model that holds EOT low for TX_LEN cycles per byte.
module tb_tdc_tx_arbiter;

    localparam int TX_LEN = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdc_tx_arbiter_if #(.N_REQ(4), .IDX_W(2)) ifa ();
    tdc_tx_arbiter_if #(.N_REQ(4), .IDX_W(2)) ifb ();

    tdc_tx_arbiter #(
        .N_REQ(4), .IDX_W(2), .HDR_BASE(8'hA0), .HDR_EN(1'b1), .GUARD_CYC(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    tdc_tx_arbiter #(
        .N_REQ(4), .IDX_W(2), .HDR_BASE(8'hA0), .HDR_EN(1'b0), .GUARD_CYC(3)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    // Transmitter models: EOT drops the cycle after STT and returns TX_LEN cycles later.
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    logic        blk_a;
    logic        glitch_b;

    always @(posedge clk) begin
        if (ifa.tx_stt === 1'b1) cnt_a <= TX_LEN;
        else if (cnt_a != 0)     cnt_a <= cnt_a - 1;
        if (ifb.tx_stt === 1'b1) cnt_b <= TX_LEN;
        else if (cnt_b != 0)     cnt_b <= cnt_b - 1;
    end

    assign ifa.tx_eot = ~blk_a & (cnt_a == 0);
    assign ifb.tx_eot = glitch_b | (cnt_b == 0);

    logic [7:0] exp_byte_a[$];
    int         exp_ack_a[$];
    logic [7:0] exp_byte_b[$];
    int         exp_ack_b[$];
    logic [7:0] last_a, last_b;
    bit         has_last_a = 1'b0;
    bit         has_last_b = 1'b0;
    int         stt_a = 0;
    int         stt_b = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0]      req;
        logic [31:0]     data;
        int              n;
        logic [3:0][1:0] ord;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    task automatic push_a(input int c, input logic [7:0] d);
        exp_byte_a.push_back(8'hA0 | 8'(c));
        exp_byte_a.push_back(d);
        exp_ack_a.push_back(c);
    endtask

    // One clock: sample at the falling edge, score both DUTs, drop acknowledged requests.
    task automatic tick();
        int e;
        @(negedge clk);
        if (ifa.tx_stt === 1'b1) begin
            stt_a++;
            if (exp_byte_a.size() == 0) flag("a_byte_unexpected", 32'(ifa.tx_d));
            else begin
                last_a     = exp_byte_a.pop_front();
                has_last_a = 1'b1;
                chk("a_tx_byte", 32'(ifa.tx_d), 32'(last_a));
            end
        end else if (ifa.busy === 1'b1 && has_last_a) begin
            chk("a_tx_d_hold", 32'(ifa.tx_d), 32'(last_a));
        end
        if (ifa.ack !== 4'b0000) begin
            chk("a_ack_onehot", 32'($onehot(ifa.ack)), 32'd1);
            chk("a_ack_with_stt", 32'(ifa.tx_stt), 32'd1);
            chk("a_busy_at_ack", 32'(ifa.busy), 32'd1);
            if (exp_ack_a.size() == 0) flag("a_ack_unexpected", 32'(ifa.ack));
            else begin
                e = exp_ack_a.pop_front();
                chk("a_ack", 32'(ifa.ack), 32'd1 << e);
                chk("a_grant_id", 32'(ifa.grant_id), 32'(e));
            end
            ifa.req = ifa.req & ~ifa.ack;
        end
        if (ifb.tx_stt === 1'b1) begin
            stt_b++;
            if (exp_byte_b.size() == 0) flag("b_byte_unexpected", 32'(ifb.tx_d));
            else begin
                last_b     = exp_byte_b.pop_front();
                has_last_b = 1'b1;
                chk("b_tx_byte", 32'(ifb.tx_d), 32'(last_b));
            end
        end else if (ifb.busy === 1'b1 && has_last_b) begin
            chk("b_tx_d_hold", 32'(ifb.tx_d), 32'(last_b));
        end
        if (ifb.ack !== 4'b0000) begin
            chk("b_ack_with_stt", 32'(ifb.tx_stt), 32'd1);
            if (exp_ack_b.size() == 0) flag("b_ack_unexpected", 32'(ifb.ack));
            else begin
                e = exp_ack_b.pop_front();
                chk("b_ack", 32'(ifb.ack), 32'd1 << e);
                chk("b_grant_id", 32'(ifb.grant_id), 32'(e));
            end
            ifb.req = ifb.req & ~ifb.ack;
        end
    endtask

    function automatic bit all_idle();
        return exp_byte_a.size() == 0 && exp_ack_a.size() == 0 &&
               exp_byte_b.size() == 0 && exp_ack_b.size() == 0 &&
               ifa.busy === 1'b0 && ifb.busy === 1'b0 &&
               ifa.req == 4'b0000 && ifb.req == 4'b0000;
    endfunction

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (!all_idle() && n < max) begin
            tick();
            n++;
        end
        if (!all_idle()) begin
            flag(name, 32'(exp_byte_a.size() + exp_byte_b.size()));
            exp_byte_a.delete(); exp_ack_a.delete();
            exp_byte_b.delete(); exp_ack_b.delete();
            ifa.req = 4'b0000;
            ifb.req = 4'b0000;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        has_last_a = 1'b0;
        has_last_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n, bc, s0;
        bit seen_ack, seen_stt;

        tbl[0] = '{4'b1111, 32'h13121110, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{4'b0100, 32'h003C0000, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[2] = '{4'b0011, 32'h0000AA55, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[3] = '{4'b1010, 32'hFE000100, 2, {2'd0, 2'd0, 2'd1, 2'd3}};
        tbl[4] = '{4'b0001, 32'h00000000, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[5] = '{4'b1001, 32'h8000007F, 2, {2'd0, 2'd0, 2'd0, 2'd3}};

        reset        = 1'b1;
        ifa.req      = 4'b0000;
        ifa.req_data = 32'h0;
        ifb.req      = 4'b0000;
        ifb.req_data = 32'h0;
        blk_a        = 1'b0;
        glitch_b     = 1'b0;
        tick();
        tick();

        chk("rst_a_ack", 32'(ifa.ack), 32'd0);
        chk("rst_a_stt", 32'(ifa.tx_stt), 32'd0);
        chk("rst_a_tx_d", 32'(ifa.tx_d), 32'd0);
        chk("rst_a_busy", 32'(ifa.busy), 32'd0);
        chk("rst_a_grant", 32'(ifa.grant_id), 32'd0);
        chk("rst_b_ack", 32'(ifb.ack), 32'd0);
        chk("rst_b_stt", 32'(ifb.tx_stt), 32'd0);
        chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        reset = 1'b0;
        tick();

        // Table: pointer carries across rows, expected service order worked out by hand.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                c = int'(tbl[r].ord[j]);
                push_a(c, tbl[r].data[8*c +: 8]);
            end
            s0           = stt_a;
            ifa.req_data = tbl[r].data;
            ifa.req      = tbl[r].req;
            wait_idle($sformatf("row%0d_timeout", r), 400);
            chk($sformatf("row%0d_grant_id", r), 32'(ifa.grant_id),
                32'(tbl[r].ord[tbl[r].n - 1]));
            chk($sformatf("row%0d_stt_count", r), 32'(stt_a - s0), 32'(2 * tbl[r].n));
        end

        // Single request with exact cycle accounting.
        do_reset();
        ifa.req_data = 32'h003C0000;
        push_a(2, 8'h3C);
        s0      = stt_a;
        ifa.req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.ack !== 4'b0100 && n < 20);
        chk("single_ack_latency", 32'(n), 32'd1);
        bc = 1;
        while (ifa.busy === 1'b1 && bc < 100) begin
            tick();
            if (ifa.busy === 1'b1) bc++;
        end
        chk("single_busy_cycles", 32'(bc), 32'd24);
        chk("single_stt_count", 32'(stt_a - s0), 32'd2);
        chk("single_grant_id", 32'(ifa.grant_id), 32'd2);
        wait_idle("single_timeout", 50);

        // Transmitter reporting busy at idle blocks capture.
        blk_a        = 1'b1;
        ifa.req_data = 32'h00007700;
        push_a(1, 8'h77);
        ifa.req  = 4'b0010;
        seen_ack = 1'b0;
        seen_stt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifa.ack !== 4'b0000) seen_ack = 1'b1;
            if (ifa.tx_stt !== 1'b0) seen_stt = 1'b1;
        end
        chk("eotlow_no_ack", 32'(seen_ack), 32'd0);
        chk("eotlow_no_stt", 32'(seen_stt), 32'd0);
        blk_a = 1'b0;
        tick();
        chk("eot_rise_ack", 32'(ifa.ack), 32'h2);
        wait_idle("eotlow_timeout", 100);

        // Fairness: ch1 re-requests right after its ack, ch3 must go first.
        do_reset();
        ifa.req_data = 32'h33001100;
        push_a(1, 8'h11);
        push_a(3, 8'h33);
        push_a(1, 8'h22);
        ifa.req = 4'b1010;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.ack !== 4'b0010 && n < 20);
        tick();
        ifa.req_data[15:8] = 8'h22;
        ifa.req[1]         = 1'b1;
        wait_idle("fair_timeout", 600);
        chk("fair_grant_id", 32'(ifa.grant_id), 32'd1);

        // Reset during DAT_WAIT with ch1 and ch3 pending; pointer returns to ch0.
        ifa.req_data = 32'h00C30000;
        push_a(2, 8'hC3);
        s0      = stt_a;
        ifa.req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.ack !== 4'b0100 && n < 20);
        ifa.req_data = 32'h66C34400;
        ifa.req      = 4'b1010;
        n = 0;
        while (stt_a < s0 + 2 && n < 40) begin
            tick();
            n++;
        end
        chk("rmid_data_sent", 32'(stt_a - s0), 32'd2);
        tick();
        tick();
        tick();
        chk("rmid_busy_before", 32'(ifa.busy), 32'd1);
        do_reset();
        chk("rmid_stt", 32'(ifa.tx_stt), 32'd0);
        chk("rmid_busy", 32'(ifa.busy), 32'd0);
        chk("rmid_ack", 32'(ifa.ack), 32'd0);
        chk("rmid_tx_d", 32'(ifa.tx_d), 32'd0);
        chk("rmid_grant", 32'(ifa.grant_id), 32'd0);
        push_a(1, 8'h44);
        push_a(3, 8'h66);
        wait_idle("rmid_timeout", 800);
        chk("rmid_last_grant", 32'(ifa.grant_id), 32'd3);

        // Data-only instance, 3-cycle guard, EOT glitch inside the guard.
        ifb.req_data = 32'h5A000000;
        exp_byte_b.push_back(8'h5A);
        exp_ack_b.push_back(3);
        s0      = stt_b;
        ifb.req = 4'b1000;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifb.ack !== 4'b1000 && n < 20);
        chk("b_ack_latency", 32'(n), 32'd1);
        bc = 1;
        tick();
        if (ifb.busy === 1'b1) bc++;
        glitch_b = 1'b1;
        tick();
        if (ifb.busy === 1'b1) bc++;
        glitch_b = 1'b0;
        while (ifb.busy === 1'b1 && bc < 100) begin
            tick();
            if (ifb.busy === 1'b1) bc++;
        end
        chk("b_busy_cycles", 32'(bc), 32'd12);
        chk("b_stt_count", 32'(stt_b - s0), 32'd1);
        chk("b_grant_id", 32'(ifb.grant_id), 32'd3);
        wait_idle("b_timeout", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
